seg7_reader: RTL



---
 rtl/seg7_pkg.sv | 17 +
 rtl/seg7_to_hex.sv | 22 ++
 rtl/seg7_reader.sv | 139 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path: the hex glyph table used by
// both the display decoder and the reader, plus the reader's FSM state type.
package seg7_pkg;

  // Segment order is g f e d c b a (bit6..bit0), active high.
  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HOLD
  } state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational reverse lookup of a segment pattern into a hex nibble; hit is low
// for any pattern that is not one of the 16 glyphs.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nib,
  output logic       hit
);

  always_comb begin
    nib = '0;
    hit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_HEX[i]) begin
        nib = 4'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_reader.sv
// Receiver for a multiplexed 7-segment bus: filters each digit pattern for stability,
// decodes it, and assembles complete multi-digit frames.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_ok,
  output logic                  frame_valid,
  output logic                  err
);

  localparam int CW = $clog2(STABLE_CYC);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(STABLE_CYC - 2);

  logic [6:0]          s_seg_q;
  logic [DIGITS-1:0]   s_sel_q;
  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   ok_q, ok_d;
  logic                fv_q, fv_d;
  logic                err_q, err_d;

  logic                changed;
  logic                inOneHot;
  logic [IW-1:0]       selIdx;
  logic [3:0]          nib;
  logic                hit;
  logic                capture;
  logic [DIGITS-1:0]   okNext;

  seg7_to_hex u_dec (
    .seg (s_seg_q),
    .nib (nib),
    .hit (hit)
  );

  // A change is seen as the new pattern is being registered, so the counter restarts
  // on the same edge that loads the input stage.
  assign changed  = (seg != s_seg_q) || (dig_sel != s_sel_q);
  assign inOneHot = (dig_sel != '0) && ((dig_sel & (dig_sel - 1'b1)) == '0);

  always_comb begin
    selIdx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (s_sel_q[i]) selIdx = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg_q  <= '0;
      s_sel_q  <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      value_q  <= '0;
      ok_q     <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s_seg_q  <= seg;
      s_sel_q  <= dig_sel;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      value_q  <= value_d;
      ok_q     <= ok_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    value_d  = value_q;
    ok_d     = ok_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;
    capture  = 1'b0;
    okNext   = '0;

    if (changed) begin
      cnt_d   = '0;
      state_d = inOneHot ? COUNT : IDLE;
    end else begin
      case (state_q)
        IDLE:  cnt_d = '0;
        COUNT: begin
          if (cnt_q == CNT_PRE) begin
            cnt_d   = CNT_LAST;
            state_d = HOLD;
            capture = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HOLD:    cnt_d = cnt_q;
        default: state_d = IDLE;
      endcase
    end

    // Frame load reads shadow_d so the digit captured on this edge is bypassed in.
    if (capture) begin
      if (hit) begin
        shadow_d[selIdx*4 +: 4] = nib;
        okNext = ok_q | (DIGITS'(1) << selIdx);
        if (&okNext) begin
          value_d = shadow_d;
          fv_d    = 1'b1;
          ok_d    = '0;
        end else begin
          ok_d = okNext;
        end
      end else begin
        err_d        = 1'b1;
        ok_d[selIdx] = 1'b0;
      end
    end
  end

  assign value       = value_q;
  assign digit_ok    = ok_q;
  assign frame_valid = fv_q;
  assign err         = err_q;

endmodule
